// File: rtl/dmem_line_server_pkg.sv
// Shared types for the data-memory line server.
// FSM states, line width and line type used by the server and its interface.
package tartaruga_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_BUSY,
    DMEM_RESP
  } dmem_state_t;

  localparam int DMEM_LINE_BYTES = 16;

  typedef logic [127:0] line_t;

endpackage

// File: rtl/dmem_line_server_if.sv
// dcache <-> data-memory req/rsp bundle.
// slave = memory responder, master = dcache requester.
interface dmem_line_server_if;
  import tartaruga_pkg::*;

  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] data_wr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_mem_addr_o;
  line_t       data_line_o;

  modport slave (
    input  req_valid_i,
    input  addr_i,
    input  we_i,
    input  data_wr_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_mem_addr_o,
    output data_line_o
  );

  modport master (
    output req_valid_i,
    output addr_i,
    output we_i,
    output data_wr_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_mem_addr_o,
    input  data_line_o
  );

endinterface

// File: rtl/dmem_line_server_array.sv
// Word-organised backing store: one word write port, one 4-word line read port.
// Byte addresses wrap modulo MEM_BYTES; contents are never reset.
module dmem_array
  import tartaruga_pkg::*;
#(
  parameter int    MEM_BYTES = 65536,
  parameter string INIT_FILE = ""
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raddr_i,
  output line_t       line_o
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int WAW   = $clog2(WORDS);

  logic [31:0]    mem [WORDS];
  logic [WAW-1:0] widx;
  logic [WAW-1:0] rbase;
  logic           unused_addr;

  assign widx  = waddr_i[WAW+1:2];
  assign rbase = raddr_i[WAW+1:2] & ~WAW'(3);

  assign unused_addr = ^{waddr_i[1:0], waddr_i[31:WAW+2],
                         raddr_i[1:0], raddr_i[31:WAW+2]};

  always_ff @(posedge clk_i) begin
    if (we_i) mem[widx] <= wdata_i;
  end

  always_comb begin
    line_o = '0;
    for (int i = 0; i < 4; i++) begin
      line_o[32*i +: 32] = mem[rbase | WAW'(i)];
    end
  end

endmodule

// File: rtl/dmem_line_server.sv
// Data-memory responder: line reads and word write-throughs with fixed latency.
// DMEM_WRITE_RSP_EN: writes also return the updated line; otherwise writes are posted.
module dmem_line_server
  import tartaruga_pkg::*;
#(
  parameter int    MEM_BYTES = 65536,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  dmem_line_server_if.slave  bus
);

  localparam int CW = $clog2(LATENCY + 1);

`ifdef DMEM_WRITE_RSP_EN
  localparam bit WR_RSP = 1'b1;
`else
  localparam bit WR_RSP = 1'b0;
`endif

  dmem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [27:0]   laddr_q, laddr_d;
  logic [31:0]   rsp_addr_q, rsp_addr_d;
  line_t         line_q, line_d;

  logic  accept;
  line_t rd_line;

  assign accept = bus.req_valid_i && (state_q == DMEM_IDLE);

  dmem_array #(
    .MEM_BYTES (MEM_BYTES),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (accept && bus.we_i),
    .waddr_i (bus.addr_i),
    .wdata_i (bus.data_wr_i),
    .raddr_i ({laddr_q, 4'h0}),
    .line_o  (rd_line)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    laddr_d    = laddr_q;
    rsp_addr_d = rsp_addr_q;
    line_d     = line_q;
    unique case (state_q)
      DMEM_IDLE: begin
        if (accept) begin
          state_d = DMEM_BUSY;
          cnt_d   = CW'(LATENCY - 1);
          we_d    = bus.we_i;
          laddr_d = bus.addr_i[31:4];
        end
      end
      DMEM_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!we_q || WR_RSP) begin
          // Line sampled now, so a write's own update is visible.
          state_d    = DMEM_RESP;
          rsp_addr_d = {laddr_q, 4'h0};
          line_d     = rd_line;
        end else begin
          state_d = DMEM_IDLE;
        end
      end
      DMEM_RESP: begin
        if (bus.rsp_ready_i) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= DMEM_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      laddr_q    <= '0;
      rsp_addr_q <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      laddr_q    <= laddr_d;
      rsp_addr_q <= rsp_addr_d;
      line_q     <= line_d;
    end
  end

  assign bus.req_ready_o    = (state_q == DMEM_IDLE);
  assign bus.rsp_valid_o    = (state_q == DMEM_RESP);
  assign bus.rsp_mem_addr_o = rsp_addr_q;
  assign bus.data_line_o    = line_q;

endmodule

// File: tb/tb_dmem_line_server.sv
// Bench for dmem_line_server: directed + random traffic against a word-array model.
// Build with or without DMEM_WRITE_RSP_EN.
module tb_dmem_line_server;
  import tartaruga_pkg::*;

  localparam int          LAT = 4;
  localparam int          MB  = 65536;
  localparam int unsigned MBU = 65536;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_line_server_if bus ();

  dmem_line_server #(
    .MEM_BYTES (MB),
    .LATENCY   (LAT),
    .INIT_FILE ("")
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  logic [31:0] mdl [128];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a % MBU) / 4;
  endfunction

  function automatic line_t exp_line(input logic [31:0] a);
    line_t r;
    int unsigned base;
    base = ((a % MBU) / 16) * 4;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = mdl[base + i];
    return r;
  endfunction

  task automatic send(input logic [31:0] a, input logic w,
                      input logic [31:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.addr_i      = a;
    bus.we_i        = w;
    bus.data_wr_i   = d;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      if (w) mdl[widx(a)] = d;
      #1;
    end
    bus.req_valid_i = 1'b0;
    chk("accept", ok, 1);
  endtask

  task automatic get_rsp(input logic [31:0] a, input int hold);
    bit    seen;
    int    lows;
    line_t el;
    seen = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        seen = 1'b1;
        break;
      end
      lows++;
    end
    chk("rsp_seen", seen, 1);
    if (!seen) return;
    chk("rsp_latency", lows, LAT);
    el = exp_line(a);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      chk("rsp_valid", bus.rsp_valid_o, 1);
      chk("rsp_addr", bus.rsp_mem_addr_o, {a[31:4], 4'h0});
      chk("rsp_line", bus.data_line_o, el);
      chk("rsp_req_ready", bus.req_ready_o, 0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    chk("rsp_drop", bus.rsp_valid_o, 0);
    chk("ready_after_hs", bus.req_ready_o, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    bit ok;
    send(a, 1'b0, 32'h0, ok);
    if (ok) get_rsp(a, hold);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    send(a, 1'b1, d, ok);
    if (!ok) return;
`ifdef DMEM_WRITE_RSP_EN
    get_rsp(a, 0);
`else
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      chk("posted_busy", bus.req_ready_o, 0);
      chk("posted_norsp", bus.rsp_valid_o, 0);
    end
    @(negedge clk);
    chk("posted_ready", bus.req_ready_o, 1);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit rose;
    logic [31:0] a;

    bus.req_valid_i = 1'b0;
    bus.addr_i      = '0;
    bus.we_i        = 1'b0;
    bus.data_wr_i   = '0;
    bus.rsp_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_addr", bus.rsp_mem_addr_o, 0);
    chk("rst_line", bus.data_line_o, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", bus.req_ready_o, 1);
    chk("rel_rsp_valid", bus.rsp_valid_o, 0);
    chk("rel_line", bus.data_line_o, 0);

    for (int i = 0; i < 128; i++) do_write(32'(i * 4), $urandom);

    do_write(32'h100, 32'hA);
    do_write(32'h104, 32'hB);
    do_read(32'h100, 0);
    chk("t1_addr", bus.rsp_mem_addr_o, 32'h100);
    chk("t1_lo64", bus.data_line_o[63:0], 64'h0000000B_0000000A);

    do_write(32'h104, 32'hDEADBEEF);
    do_read(32'h10C, 0);
    chk("t2_word1", bus.data_line_o[63:32], 32'hDEADBEEF);

    do_read(32'h140, 10);

    do_read(32'h0001_0020, 0);
    chk("wrap_addr", bus.rsp_mem_addr_o, 32'h0001_0020);
    chk("wrap_line", bus.data_line_o, exp_line(32'h20));

    do_write(32'h103, 32'h12345678);
    do_read(32'h100, 0);
    chk("lowbits_word0", bus.data_line_o[31:0], 32'h12345678);

    do_write(32'h1F0, 32'hCAFEF00D);
    send(32'h1F0, 1'b0, 32'h0, ok);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_valid", bus.rsp_valid_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rose |= bus.rsp_valid_o;
    end
    chk("midrst_no_rsp", rose, 0);
    chk("midrst_ready", bus.req_ready_o, 1);
    do_read(32'h1F0, 0);
    chk("midrst_kept", bus.data_line_o[31:0], 32'hCAFEF00D);

    for (int n = 0; n < 30; n++) begin
      a = 32'($urandom_range(0, 127) * 4) | 32'($urandom_range(0, 3))
        | (32'($urandom_range(0, 3)) << 16);
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
      else do_read(a, int'($urandom_range(0, 3)));
    end

    begin : b2b
      logic [31:0] ba [3];
      int acc_c [3];
      int n_acc;
      int n_rsp;
      bit acc;
      ba[0] = 32'h0;
      ba[1] = 32'h50;
      ba[2] = 32'h1A0;
      n_acc = 0;
      n_rsp = 0;
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.we_i        = 1'b0;
      bus.addr_i      = ba[0];
      for (int c = 0; c < 200 && (n_acc < 3 || n_rsp < 3); c++) begin
        if (bus.rsp_valid_o && n_rsp < 3) begin
          chk("b2b_addr", bus.rsp_mem_addr_o, {ba[n_rsp][31:4], 4'h0});
          chk("b2b_line", bus.data_line_o, exp_line(ba[n_rsp]));
          n_rsp++;
        end
        acc = bus.req_valid_i && bus.req_ready_o;
        if (acc) begin
          acc_c[n_acc] = cyc;
          n_acc++;
        end
        @(posedge clk);
        #1;
        if (acc) begin
          if (n_acc < 3) bus.addr_i = ba[n_acc];
          else bus.req_valid_i = 1'b0;
        end
        @(negedge clk);
      end
      bus.req_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b0;
      chk("b2b_accepts", n_acc, 3);
      chk("b2b_rsps", n_rsp, 3);
      if (n_acc == 3) begin
        for (int i = 1; i < 3; i++) begin
          chk("b2b_gap", (acc_c[i] - acc_c[i-1]) >= LAT + 1, 1);
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
